// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and master FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WR      = 3'd1;
  localparam state_t S_WR_RESP = 3'd2;
  localparam state_t S_RD_ADDR = 3'd3;
  localparam state_t S_RD_DATA = 3'd4;
  localparam state_t S_DONE    = 3'd5;

  function automatic logic is_busy(input state_t s);
    return (s == S_WR) || (s == S_WR_RESP) || (s == S_RD_ADDR) || (s == S_RD_DATA);
  endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Transaction watchdog: counts busy cycles since command acceptance.
module axi_lite_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = active && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
// Optional watchdog abort compiled in with AXI_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  cmd_valid,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  cmd_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic                    aw_done, w_done;
  logic                    accept, aw_hs, w_hs, expired;

  assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;
  assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;

`ifdef AXI_MASTER_TIMEOUT_EN
  logic timed_out;

  axi_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (M_AXI_ACLK),
    .rst_n  (M_AXI_ARESETN),
    .clear  (accept),
    .active (is_busy(state)),
    .expired(expired)
  );

  assign rsp_timeout = timed_out;
`else
  assign expired     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      timed_out     <= 1'b0;
`endif
    end else if (expired) begin
      // Abort takes priority over any handshake landing on the same edge.
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b1;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_SLVERR;
      state         <= S_DONE;
`ifdef AXI_MASTER_TIMEOUT_EN
      timed_out     <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            if (cmd_write) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= S_WR;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            rsp_valid    <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
`ifdef AXI_MASTER_TIMEOUT_EN
            timed_out <= 1'b0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
